// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared pipeline types and constants for the MEM stage
package memory_access_pkg;

    localparam int WORD_W          = 64;
    localparam int TIMEOUT_CYC_DEF = 15;
    localparam int CNT_W           = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
module mem_wb_reg
    import memory_access_pkg::*;
(
    input  logic              clk,
    input  logic              resetl,
    input  logic              bubble,
    input  logic              regwrite_in,
    input  logic              mem2reg_in,
    input  logic [4:0]        rd_in,
    input  logic [WORD_W-1:0] aluout_in,
    input  logic              memdata_load,
    input  logic [WORD_W-1:0] memdata_in,
    output logic              regwrite_wb,
    output logic              mem2reg_wb,
    output logic [4:0]        rd_wb,
    output logic [WORD_W-1:0] aluout_wb,
    output logic [WORD_W-1:0] memdata_wb
);

    logic              regwrite_q, regwrite_d;
    logic              mem2reg_q,  mem2reg_d;
    logic [4:0]        rd_q,       rd_d;
    logic [WORD_W-1:0] aluout_q,   aluout_d;
    logic [WORD_W-1:0] memdata_q,  memdata_d;

    // A bubble only kills the register write; the other fields keep their value.
    always_comb begin
        regwrite_d = 1'b0;
        mem2reg_d  = mem2reg_q;
        rd_d       = rd_q;
        aluout_d   = aluout_q;
        memdata_d  = memdata_q;
        if (!bubble) begin
            regwrite_d = regwrite_in;
            mem2reg_d  = mem2reg_in;
            rd_d       = rd_in;
            aluout_d   = aluout_in;
        end
        if (memdata_load) begin
            memdata_d = memdata_in;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            regwrite_q <= 1'b0;
            mem2reg_q  <= 1'b0;
            rd_q       <= 5'd0;
            aluout_q   <= '0;
            memdata_q  <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            mem2reg_q  <= mem2reg_d;
            rd_q       <= rd_d;
            aluout_q   <= aluout_d;
            memdata_q  <= memdata_d;
        end
    end

    assign regwrite_wb = regwrite_q;
    assign mem2reg_wb  = mem2reg_q;
    assign rd_wb       = rd_q;
    assign aluout_wb   = aluout_q;
    assign memdata_wb  = memdata_q;

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: branch resolve, data-memory handshake FSM, MEM/WB
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              RegWrite_MEM,
    input  logic              Branch_MEM,
    input  logic              Uncondbranch_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              Mem2Reg_MEM,
    input  logic              ALUzero_MEM,
    input  logic [4:0]        RD_MEM,
    input  logic [WORD_W-1:0] ALUout_MEM,
    input  logic [WORD_W-1:0] RegOutB_MEM,
    input  logic [WORD_W-1:0] PCtarget_MEM,
    output logic              PCSrc,
    output logic [WORD_W-1:0] PCtarget_IF,
    output logic              Stall_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              RegWrite_WB,
    output logic              Mem2Reg_WB,
    output logic [4:0]        RD_WB,
    output logic [WORD_W-1:0] ALUout_WB,
    output logic [WORD_W-1:0] MemData_WB,
    output logic              mem_fault
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              req_q,   req_d;
    logic              we_q,    we_d;
    logic [WORD_W-1:0] addr_q,  addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;

    logic access, both_rw, misaligned, legal, busy, timeout;
    logic stall, fault_now, bubble, memdata_load;

    always_comb begin
        access       = MemRead_MEM ^ MemWrite_MEM;
        both_rw      = MemRead_MEM & MemWrite_MEM;
        misaligned   = access & (ALUout_MEM[2:0] != 3'b000);
        legal        = access & ~misaligned;
        busy         = (state_q == ST_BUSY);
        // The last permitted BUSY cycle without ack releases the pipeline itself.
        timeout      = busy & ~dmem_ack & (cnt_q == TO_LAST);
        stall        = (~busy & legal) | (busy & ~dmem_ack & ~timeout);
        fault_now    = (~busy & (both_rw | misaligned)) | timeout;
        bubble       = stall | fault_now;
        memdata_load = busy & dmem_ack & ~we_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q | fault_now;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = MemWrite_MEM;
                    addr_d  = ALUout_MEM;
                    wdata_d = RegOutB_MEM;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || timeout) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .resetl       (resetl),
        .bubble       (bubble),
        .regwrite_in  (RegWrite_MEM),
        .mem2reg_in   (Mem2Reg_MEM),
        .rd_in        (RD_MEM),
        .aluout_in    (ALUout_MEM),
        .memdata_load (memdata_load),
        .memdata_in   (dmem_rdata),
        .regwrite_wb  (RegWrite_WB),
        .mem2reg_wb   (Mem2Reg_WB),
        .rd_wb        (RD_WB),
        .aluout_wb    (ALUout_WB),
        .memdata_wb   (MemData_WB)
    );

    assign PCSrc       = Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM);
    assign PCtarget_IF = PCtarget_MEM;
    assign Stall_MEM   = stall;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign mem_fault   = fault_q;

endmodule
